// File: rtl/ah_div_pipelined_param.sv
// Fully pipelined restoring divider: one quotient bit per stage, signed or unsigned per operation,
// with tag passthrough and a whole-pipe stall driven by the output handshake.
module ah_div_pipelined_param #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [TAG_W-1:0] out_tag
);

    // q starts as the dividend magnitude; its MSB is shifted into rem each step while
    // quotient bits enter at the LSB. The signed flag is folded into neg_q/neg_r at capture.
    typedef struct packed {
        logic             neg_q;
        logic             neg_r;
        logic             dbz;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] dvs;
    } stage_t;

    logic             advance;
    logic [WIDTH:0]   valid;
    stage_t           st      [0:WIDTH];
    stage_t           nxt     [0:WIDTH];
    logic [WIDTH:0]   shifted [1:WIDTH];
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // Global stall: the pipe moves only when the output slot is empty or being taken.
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    always_comb begin
        nxt[0].neg_q = in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        nxt[0].neg_r = in_signed & dividend[WIDTH-1];
        nxt[0].dbz   = (divisor == '0);
        nxt[0].ovf   = in_signed & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (divisor == '1);
        nxt[0].tag   = in_tag;
        nxt[0].rem   = '0;
        nxt[0].q     = (in_signed & dividend[WIDTH-1]) ? -dividend : dividend;
        nxt[0].dvs   = (in_signed & divisor[WIDTH-1]) ? -divisor : divisor;
        for (int k = 1; k <= WIDTH; k++) begin
            shifted[k] = {st[k-1].rem, st[k-1].q[WIDTH-1]};
            nxt[k]     = st[k-1];
            // After a successful subtract the partial remainder is below dvs, so WIDTH bits hold it.
            if (shifted[k] >= {1'b0, st[k-1].dvs}) begin
                nxt[k].rem = shifted[k][WIDTH-1:0] - st[k-1].dvs;
                nxt[k].q   = {st[k-1].q[WIDTH-2:0], 1'b1};
            end else begin
                nxt[k].rem = shifted[k][WIDTH-1:0];
                nxt[k].q   = {st[k-1].q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // With a zero divisor the remainder path ends holding |dividend|; re-applying the sign restores it.
    always_comb begin
        q_fin = st[WIDTH].neg_q ? -st[WIDTH].q : st[WIDTH].q;
        r_fin = st[WIDTH].neg_r ? -st[WIDTH].rem : st[WIDTH].rem;
        if (st[WIDTH].dbz) begin
            q_fin = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (advance) begin
            valid <= {valid[WIDTH-1:0], in_valid & in_ready};
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k <= WIDTH; k++) begin
                st[k] <= nxt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_tag     <= '0;
        end else if (advance) begin
            out_valid <= valid[WIDTH];
            if (valid[WIDTH]) begin
                quotient    <= q_fin;
                remainder   <= r_fin;
                div_by_zero <= st[WIDTH].dbz;
                overflow    <= st[WIDTH].ovf;
                out_tag     <= st[WIDTH].tag;
            end
        end
    end

endmodule

// File: tb/tb_ah_div_pipelined_param.sv
// Bench for ah_div_pipelined_param (WIDTH=8): directed vector table, random stalled stream,
// mid-flight reset and a wide operand sweep, all checked against an in-order scoreboard.
module tb_ah_div_pipelined_param;
    localparam int WIDTH = 8;
    localparam int TAG_W = 4;
    localparam int RW    = TAG_W + 2 * WIDTH + 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;
    logic [TAG_W-1:0] out_tag;

    ah_div_pipelined_param #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow), .out_tag(out_tag)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q[$];
    logic rand_ready = 1'b0;

    typedef struct {
        logic             sgn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        logic             edz;
        logic             eov;
    } vec_t;

    vec_t vecs[14];
    logic [WIDTH-1:0] sweep_div[16];

    wire [RW-1:0] out_word = {out_tag, quotient, remainder, div_by_zero, overflow};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic sgn, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        logic [WIDTH-1:0] q, r;
        logic dz, ov;
        int sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (sgn && a == 8'h80 && b == 8'hFF) begin
            q = 8'h80; r = '0; ov = 1'b1;
        end else if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = WIDTH'(sa / sb);
            r = WIDTH'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {t, q, r, dz, ov};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [RW-1:0] prev_word;
    logic          prev_stall = 1'b0;
    logic [RW-1:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) check("stall_hold", {out_valid, out_word}, {1'b1, prev_word});
            if (in_valid && in_ready) exp_q.push_back(model(in_signed, dividend, divisor, in_tag));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_result", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", out_word, e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = out_word;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_op(input logic sgn, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        logic acc;
        int n;
        in_signed = sgn; dividend = a; divisor = b; in_tag = t;
        in_valid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) check("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        in_signed = v.sgn; dividend = v.a; divisor = v.b; in_tag = v.tag;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, WIDTH + 2);
        check("vector", out_word, {v.tag, v.eq, v.er, v.edz, v.eov});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{1'b0, 8'd100, 8'd7,  4'h1, 8'd14,  8'd2,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h9C,  8'd7,  4'h2, 8'hF2,  8'hFE, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'd100, 8'hF9, 4'h3, 8'hF2,  8'h02, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'd200, 8'd0,  4'h4, 8'hFF,  8'd200,1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h80,  8'hFF, 4'h5, 8'h80,  8'h00, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 8'h9C,  8'h00, 4'h6, 8'hFF,  8'h9C, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'hFF,  8'h01, 4'h7, 8'hFF,  8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h80,  8'hFF, 4'h8, 8'h00,  8'h80, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'hF9,  8'h02, 4'h9, 8'hFD,  8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h07,  8'hFE, 4'hA, 8'hFD,  8'h01, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h80,  8'h02, 4'hB, 8'hC0,  8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h05,  8'h09, 4'hC, 8'h00,  8'h05, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'hFF,  8'hFF, 4'hD, 8'h01,  8'h00, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h80,  8'h01, 4'hE, 8'h80,  8'h00, 1'b0, 1'b0};
        sweep_div = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h0D, 8'h10,
                      8'h3F, 8'h7F, 8'h80, 8'h81, 8'hC0, 8'hF9, 8'hFE, 8'hFF};

        rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        dividend = '0; divisor = '0; in_tag = '0; out_ready = 1'b1;
        #12;
        check("reset_outputs", {out_valid, out_word}, '0);
        check("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // random stream with back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            send_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 4'(i));
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        // reset with operations in flight
        for (int i = 0; i < 5; i++) send_op(1'b0, 8'(50 + i), 8'd3, 4'(i));
        for (int i = 0; i < 6; i++) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {out_valid, out_word}, '0);
        check("async_reset_in_ready", in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        run_vec('{1'b0, 8'd9, 8'd3, 4'hF, 8'd3, 8'd0, 1'b0, 1'b0});

        // operand sweep at full throughput, both modes
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                for (int d = 0; d < 16; d++)
                    send_op(1'(s), 8'(a), sweep_div[d], 4'(a + d));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
